// File: rtl/core_data_req_buffer.sv
// Elastic request/response stage between a cluster core data port and the
// TCDM/peripheral interconnect. One registered request slot, a registered
// response path, an in-flight credit counter and a hold/drain handshake that
// lets recovery logic quiesce the core's memory traffic.
module core_data_req_buffer #(
   parameter  int unsigned MAX_OUTSTANDING = 4,
   localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             core_req_i,
   input  logic [31:0]      core_add_i,
   input  logic             core_we_i,
   input  logic [31:0]      core_wdata_i,
   input  logic [3:0]       core_be_i,
   output logic             core_gnt_o,
   output logic             core_r_valid_o,
   output logic [31:0]      core_r_rdata_o,
   output logic             mem_req_o,
   output logic [31:0]      mem_add_o,
   output logic             mem_we_o,
   output logic [31:0]      mem_wdata_o,
   output logic [3:0]       mem_be_o,
   input  logic             mem_gnt_i,
   input  logic             mem_r_valid_i,
   input  logic [31:0]      mem_r_rdata_i,
   input  logic             hold_i,
   output logic             drained_o,
   output logic [CNT_W-1:0] inflight_o,
   output logic             err_o
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   logic [1:0]       r_state;
   logic             r_stage_valid;
   logic [31:0]      r_add;
   logic             r_we;
   logic [31:0]      r_wdata;
   logic [3:0]       r_be;
   logic [CNT_W-1:0] r_inflight;
   logic             r_rvalid;
   logic [31:0]      r_rdata;
   logic             r_err;

   logic             w_grant;
   logic             w_accept;
   logic             w_discard;
   logic             w_quiet;
   logic [CNT_W-1:0] w_unanswered;

   // Transactions accepted but whose response has not yet been captured.
   assign w_unanswered = r_inflight - (r_rvalid ? ONE_CNT : '0);

   // Grant gating: only in RUN, no hold, slot free or freeing, credit left.
   always_comb begin
      w_grant = core_req_i & (r_state == ST_RUN) & ~hold_i &
                (~r_stage_valid | mem_gnt_i) & (r_inflight < MAX_CNT);
   end

   assign w_accept  = core_req_i & w_grant;
   assign w_discard = mem_r_valid_i & (w_unanswered == '0);

   // The response currently in the register retires on this edge, so the
   // stage is quiet once nothing is staged and nothing else is unanswered;
   // drained_o then rises the cycle after the last core response.
   assign w_quiet = ~r_stage_valid & (w_unanswered == '0);

   // Request slot: load on accept, free on interconnect grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stage_valid <= 1'b0;
         r_add         <= '0;
         r_we          <= 1'b0;
         r_wdata       <= '0;
         r_be          <= '0;
      end else if (w_accept) begin
         r_stage_valid <= 1'b1;
         r_add         <= core_add_i;
         r_we          <= core_we_i;
         r_wdata       <= core_wdata_i;
         r_be          <= core_be_i;
      end else if (mem_gnt_i && r_stage_valid) begin
         r_stage_valid <= 1'b0;
      end
   end

   // Response register: forward matched responses, hold data otherwise.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= mem_r_valid_i & ~w_discard;
         if (mem_r_valid_i && !w_discard) begin
            r_rdata <= mem_r_rdata_i;
         end
      end
   end

   // In-flight counter: up on accept, down when a response reaches the core.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_inflight <= '0;
      end else begin
         case ({w_accept, r_rvalid})
            2'b10:   r_inflight <= r_inflight + ONE_CNT;
            2'b01:   r_inflight <= r_inflight - ONE_CNT;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Sticky error on a response nothing is waiting for.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err <= 1'b0;
      end else if (w_discard) begin
         r_err <= 1'b1;
      end
   end

   // Hold/drain state machine.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (hold_i) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!hold_i)      r_state <= ST_RUN;
               else if (w_quiet) r_state <= ST_HALTED;
            end
            ST_HALTED: begin
               if (!hold_i) r_state <= ST_RUN;
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign core_gnt_o     = w_grant;
   assign core_r_valid_o = r_rvalid;
   assign core_r_rdata_o = r_rdata;
   assign mem_req_o      = r_stage_valid;
   assign mem_add_o      = r_add;
   assign mem_we_o       = r_we;
   assign mem_wdata_o    = r_wdata;
   assign mem_be_o       = r_be;
   assign drained_o      = (r_state == ST_HALTED);
   assign inflight_o     = r_inflight;
   assign err_o          = r_err;

endmodule
